// File: rtl/riscv_pkg.sv
// Shared core types: redirect source select, fetch queue entry layout and default queue depth.
package riscv_pkg;

  typedef enum logic [1:0] {
    PC_JUMP = 2'd0,
    PC_MEPC = 2'd1,
    PC_TRAP = 2'd2
  } pc_sel_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  localparam int FETCH_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue with alloc/fill/read pointers and a discard counter for stale responses.
// FETCH_BYPASS_EN: head may be presented straight from the response data while it fills.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear,
  input  logic        alloc_en,
  input  logic [31:0] alloc_pc,
  input  logic        rvalid,
  input  logic [31:0] rdata,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic        head_valid,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int DW = PW + 4;

  fetch_entry_t    entries_reg [DEPTH];
  logic [PW-1:0]   alloc_ptr_reg;
  logic [PW-1:0]   fill_ptr_reg;
  logic [PW-1:0]   read_ptr_reg;
  logic [DW-1:0]   discard_reg;
  logic [DW-1:0]   discard_next;
  logic [PW-1:0]   count;
  logic [PW-1:0]   pending;
  logic            fill_en;
  logic            drop_en;
  logic            head_fill_now;
  fetch_entry_t    head;

  assign count         = alloc_ptr_reg - read_ptr_reg;
  assign pending       = alloc_ptr_reg - fill_ptr_reg;
  assign full          = (count == PW'(DEPTH));
  assign empty         = (count == '0);
  assign drop_en       = rvalid && (discard_reg != '0);
  assign fill_en       = rvalid && (discard_reg == '0) && (pending != '0);
  assign head_fill_now = fill_en && (fill_ptr_reg == read_ptr_reg);
  assign head          = entries_reg[read_ptr_reg[AW-1:0]];
  assign head_pc       = head.pc;

`ifdef FETCH_BYPASS_EN
  assign head_valid = (!empty && head.filled) || head_fill_now;
  assign head_instr = head.filled ? head.instr : rdata;
`else
  assign head_valid = !empty && head.filled && !head_fill_now;
  assign head_instr = head.instr;
`endif

  // Requests still in flight once this cycle's grant and response have been applied.
  always_comb begin
    discard_next = discard_reg + DW'(pending) + DW'(alloc_en);
    if (drop_en || fill_en) begin
      discard_next = discard_next - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      read_ptr_reg  <= '0;
      discard_reg   <= '0;
    end else if (clear) begin
      alloc_ptr_reg <= '0;
      fill_ptr_reg  <= '0;
      read_ptr_reg  <= '0;
      discard_reg   <= discard_next;
    end else begin
      if (alloc_en) alloc_ptr_reg <= alloc_ptr_reg + PW'(1);
      if (fill_en)  fill_ptr_reg  <= fill_ptr_reg + PW'(1);
      if (pop)      read_ptr_reg  <= read_ptr_reg + PW'(1);
      if (drop_en)  discard_reg   <= discard_reg - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        entries_reg[alloc_ptr_reg[AW-1:0]].pc     <= alloc_pc;
        entries_reg[alloc_ptr_reg[AW-1:0]].filled <= 1'b0;
      end
      if (fill_en) begin
        entries_reg[fill_ptr_reg[AW-1:0]].instr  <= rdata;
        entries_reg[fill_ptr_reg[AW-1:0]].filled <= 1'b1;
      end
    end
  end

  // A response with nothing pending and nothing to discard means the memory broke protocol.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(rvalid && (discard_reg == '0) && (pending == '0)));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, redirect/flush handling, memory requests and IF/ID presentation.
// FETCH_BYPASS_EN: present returning instructions combinationally when they fill the queue head.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        new_pc_en_i,
  input  pc_sel_t     pc_sel_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mtvec_i,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] if_pc_o
);

  logic [31:0] fetch_pc_reg;
  logic [31:0] fetch_pc_next;
  logic [31:0] redirect_pc;
  logic        full;
  logic        empty;
  logic        head_valid;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic        alloc_en;
  logic        pop;
  logic        clear;
  logic        block;

  always_comb begin
    case (pc_sel_i)
      PC_JUMP: redirect_pc = jump_target_i;
      PC_MEPC: redirect_pc = mepc_i;
      default: redirect_pc = mtvec_i & ~32'h3;
    endcase
  end

  // Redirect and flush cycles neither request nor dispatch; the queue is rebuilt next cycle.
  assign block         = rst_i || new_pc_en_i || flush_i;
  assign clear         = new_pc_en_i || flush_i;
  assign imem_req_o    = !full && !block;
  assign imem_addr_o   = {fetch_pc_reg[31:2], 2'b00};
  assign alloc_en      = imem_req_o && imem_gnt_i;
  assign instr_valid_o = head_valid && !block;
  assign instr_o       = instr_valid_o ? head_instr : 32'h0;
  assign instr_pc_o    = instr_valid_o ? head_pc : 32'h0;
  assign if_pc_o       = empty ? fetch_pc_reg : head_pc;
  assign pop           = instr_valid_o && !stall_i;

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (new_pc_en_i) begin
      fetch_pc_next = redirect_pc;
    end else if (flush_i) begin
      fetch_pc_next = if_pc_o;
    end else if (alloc_en) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_reg <= BOOT_ADDR;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (clear),
    .alloc_en   (alloc_en),
    .alloc_pc   (fetch_pc_reg),
    .rvalid     (imem_rvalid_i),
    .rdata      (imem_rdata_i),
    .pop        (pop),
    .full       (full),
    .empty      (empty),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: in-order memory model with configurable latency.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam logic [31:0] BOOT  = 32'h8000_0000;
  localparam int          DEPTH = 4;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_LAT = 1;
`else
  localparam int FIRST_LAT = 2;
`endif

  typedef struct { logic [31:0] data; int due; } mem_rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; int cyc; } disp_t;
  typedef struct { logic [31:0] addr; int cyc; } grant_t;

  logic        clk;
  logic        rst;
  logic        new_pc_en;
  pc_sel_t     pc_sel;
  logic [31:0] jump_target, mepc, mtvec;
  logic        stall, flush;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc, if_pc;

  fetch_stage #(.BOOT_ADDR(BOOT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .new_pc_en_i(new_pc_en), .pc_sel_i(pc_sel),
    .jump_target_i(jump_target), .mepc_i(mepc), .mtvec_i(mtvec),
    .stall_i(stall), .flush_i(flush),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc), .if_pc_o(if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, errors, cyc, lat;
  logic gnt_en;
  mem_rsp_t    mem_q[$];
  disp_t       obs_q[$];
  grant_t      gnt_q[$];
  logic [31:0] exp_q[$];
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_ifpc;

  function automatic logic [31:0] mk(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // One clock: drive memory response and grant, sample outputs, log dispatches and grants.
  task automatic tick();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_q[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    imem_gnt = gnt_en & imem_req;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_ifpc = if_pc;
    if (s_valid && !stall) obs_q.push_back('{pc: s_pc, instr: s_instr, cyc: cyc});
    if (imem_rvalid) mem_q.delete(0);
    if (s_req && imem_gnt) begin
      mem_q.push_back('{data: mk(s_addr), due: cyc + lat});
      gnt_q.push_back('{addr: s_addr, cyc: cyc});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1; new_pc_en = 1'b0; stall = 1'b0; flush = 1'b0; gnt_en = 1'b1;
    pc_sel = PC_JUMP; jump_target = 32'h0; mepc = 32'h0; mtvec = 32'h0;
    lat = l;
    mem_q.delete();
    tick(); tick();
    rst = 1'b0;
    obs_q.delete(); gnt_q.delete(); exp_q.delete();
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset(1);
    rst = 1'b1;
    tick();
    checks += 5;
    if (s_req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", s_req); end
    if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", s_valid); end
    if (s_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", s_instr); end
    if (s_pc !== 32'h0)   begin errors++; $display("FAIL reset_pc got %h want 0", s_pc); end
    if (s_ifpc !== BOOT)  begin errors++; $display("FAIL reset_ifpc got %h want %h", s_ifpc, BOOT); end
    rst = 1'b0;
    mem_q.delete();
    tick();
    checks++;
    if (s_addr !== BOOT || s_req !== 1'b1) begin
      errors++; $display("FAIL reset_first_req got %h/%b want %h/1", s_addr, s_req, BOOT);
    end
  endtask

  task automatic test_sequential();
    disp_t o;
    logic [31:0] e;
    do_reset(1);
    for (int k = 0; k < 3; k++) exp_q.push_back(BOOT + 32'(4 * k));
    repeat (6) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (gnt_q.size() <= k) begin
        errors++; $display("FAIL seq_grant%0d missing grant want %h", k, BOOT + 32'(4 * k));
      end else if (gnt_q[k].addr !== BOOT + 32'(4 * k) || gnt_q[k].cyc != k) begin
        errors++; $display("FAIL seq_grant%0d got %h@%0d want %h@%0d", k, gnt_q[k].addr,
                           gnt_q[k].cyc, BOOT + 32'(4 * k), k);
      end
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL seq_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e) || o.cyc != FIRST_LAT + k) begin
          errors++; $display("FAIL seq_disp got %h/%h@%0d want %h/%h@%0d", o.pc, o.instr, o.cyc,
                             e, mk(e), FIRST_LAT + k);
        end
      end
    end
  endtask

  task automatic test_stall();
    disp_t o;
    logic [31:0] e;
    int first_cyc;
    do_reset(1);
    stall = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c >= 2) begin
        checks++;
        if (s_valid !== 1'b1 || s_instr !== mk(BOOT)) begin
          errors++; $display("FAIL stall_hold c%0d got %b/%h want 1/%h", c, s_valid, s_instr, mk(BOOT));
        end
      end
    end
    checks += 2;
    if (gnt_q.size() != DEPTH) begin
      errors++; $display("FAIL stall_grants got %0d want %0d", gnt_q.size(), DEPTH);
    end
    if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", s_req); end
    stall = 1'b0;
    for (int k = 0; k < DEPTH; k++) exp_q.push_back(BOOT + 32'(4 * k));
    repeat (6) tick();
    first_cyc = 6;
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL stall_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e) || o.cyc != first_cyc + k) begin
          errors++; $display("FAIL stall_disp got %h@%0d want %h@%0d", o.pc, o.cyc, e, first_cyc + k);
        end
      end
    end
  endtask

  task automatic test_redirect();
    disp_t o;
    logic [31:0] e;
    do_reset(3);
    repeat (3) tick();
    checks++;
    if (gnt_q.size() != 3) begin errors++; $display("FAIL redir_outstanding got %0d want 3", gnt_q.size()); end
    new_pc_en = 1'b1; pc_sel = PC_JUMP; jump_target = 32'h100;
    tick();
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b want 0", s_valid); end
    new_pc_en = 1'b0;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
    repeat (14) tick();
    checks++;
    if (gnt_q.size() < 4) begin
      errors++; $display("FAIL redir_grant missing grant want 00000100");
    end else if (gnt_q[3].addr !== 32'h100 || gnt_q[3].cyc != 4) begin
      errors++; $display("FAIL redir_grant got %h@%0d want 00000100@4", gnt_q[3].addr, gnt_q[3].cyc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL redir_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e)) begin
          errors++; $display("FAIL redir_disp got %h/%h want %h/%h", o.pc, o.instr, e, mk(e));
        end
      end
    end
  endtask

  task automatic test_trap_mepc();
    disp_t o;
    logic [31:0] e;
    do_reset(1);
    repeat (3) tick();
    new_pc_en = 1'b1; pc_sel = PC_TRAP; mtvec = 32'h203;
    tick();
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL trap_valid got %b want 0", s_valid); end
    new_pc_en = 1'b0;
    tick();
    checks++;
    if (s_addr !== 32'h200 || s_req !== 1'b1) begin
      errors++; $display("FAIL trap_addr got %h/%b want 00000200/1", s_addr, s_req);
    end
    new_pc_en = 1'b1; pc_sel = PC_MEPC; mepc = 32'h44;
    tick();
    new_pc_en = 1'b0;
    obs_q.delete();
    exp_q.push_back(32'h44); exp_q.push_back(32'h48);
    tick();
    checks++;
    if (s_addr !== 32'h44 || s_req !== 1'b1) begin
      errors++; $display("FAIL mepc_addr got %h/%b want 00000044/1", s_addr, s_req);
    end
    repeat (6) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL mepc_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e)) begin
          errors++; $display("FAIL mepc_disp got %h/%h want %h/%h", o.pc, o.instr, e, mk(e));
        end
      end
    end
  endtask

  task automatic test_flush();
    disp_t o;
    logic [31:0] e;
    do_reset(1);
    stall = 1'b1;
    new_pc_en = 1'b1; pc_sel = PC_JUMP; jump_target = 32'h10;
    tick();
    new_pc_en = 1'b0;
    tick(); tick();
    gnt_en = 1'b0;
    tick();
    checks++;
    if (gnt_q.size() != 2) begin errors++; $display("FAIL flush_setup got %0d grants want 2", gnt_q.size()); end
    flush = 1'b1;
    tick();
    checks += 2;
    if (s_ifpc !== 32'h10) begin errors++; $display("FAIL flush_ifpc got %h want 00000010", s_ifpc); end
    if (s_valid !== 1'b0 || s_req !== 1'b0) begin
      errors++; $display("FAIL flush_quiet got %b/%b want 0/0", s_valid, s_req);
    end
    flush = 1'b0; stall = 1'b0; gnt_en = 1'b1;
    exp_q.push_back(32'h10); exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    tick();
    checks++;
    if (s_addr !== 32'h10 || s_req !== 1'b1) begin
      errors++; $display("FAIL flush_refetch got %h/%b want 00000010/1", s_addr, s_req);
    end
    repeat (6) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL flush_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e)) begin
          errors++; $display("FAIL flush_disp got %h/%h want %h/%h", o.pc, o.instr, e, mk(e));
        end
      end
    end
  endtask

  task automatic test_wrap();
    disp_t o;
    logic [31:0] e;
    do_reset(1);
    new_pc_en = 1'b1; pc_sel = PC_JUMP; jump_target = 32'hFFFF_FFFC;
    tick();
    new_pc_en = 1'b0;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
    tick();
    checks++;
    if (s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last got %h want fffffffc", s_addr); end
    tick();
    checks++;
    if (s_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h want 00000000", s_addr); end
    repeat (5) tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wrap_disp missing dispatch want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o.pc !== e || o.instr !== mk(e)) begin
          errors++; $display("FAIL wrap_disp got %h/%h want %h/%h", o.pc, o.instr, e, mk(e));
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; lat = 1; gnt_en = 1'b1;
    rst = 1'b1; new_pc_en = 1'b0; pc_sel = PC_JUMP; jump_target = 32'h0;
    mepc = 32'h0; mtvec = 32'h0; stall = 1'b0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_trap_mepc();
    test_flush();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
